// File: rtl/dmem_arbiter.sv
// Arbitrates IF and LS requesters onto a single 32-byte data memory.
// When DMEM_ARB_STATS_EN is defined, saturating response counters are added.
module dmem_arbiter #(
   parameter int unsigned MEM_BYTES  = 32,
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_gnt,
   output logic        ls_rvalid,
   output logic [31:0] ls_rdata,
   output logic        ls_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0] stat_if_cnt,
   output logic [15:0] stat_ls_rd_cnt,
   output logic [15:0] stat_ls_wr_cnt,
   output logic [15:0] stat_err_cnt
`endif
);

   localparam int unsigned LAST_WORD = MEM_BYTES - 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        owner_q;       // 1 = LS
   logic        last_owner_q;  // 1 = LS
   logic [31:0] addr_q;
   logic        we_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic [31:0] rdata_q;

   logic        any_req;
   logic        win_ls;
   logic [31:0] win_addr;
   logic        win_legal;
   logic        grant;

   // Winner selection; only acted upon in IDLE
   always_comb begin
      any_req = if_req | ls_req;
      win_ls  = 1'b0;
      if (ls_req && !if_req) begin
         win_ls = 1'b1;
      end else if (ls_req && if_req) begin
         win_ls = (FIXED_PRIO != 0) ? 1'b1 : ~last_owner_q;
      end
      win_addr  = win_ls ? ls_addr : if_addr;
      win_legal = (win_addr[1:0] == 2'b00) && (win_addr <= 32'(LAST_WORD));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      if_gnt  = 1'b0;
      ls_gnt  = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant   = 1'b1;
               if_gnt  = ~win_ls;
               ls_gnt  = win_ls;
               state_d = win_legal ? ACCESS : RESP;
            end
         end
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Transaction latch at grant; read data captured at the end of ACCESS
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         addr_q       <= 32'd0;
         we_q         <= 1'b0;
         wdata_q      <= 32'd0;
         err_q        <= 1'b0;
         rdata_q      <= 32'd0;
      end else if (grant) begin
         owner_q      <= win_ls;
         last_owner_q <= win_ls;
         addr_q       <= win_addr;
         we_q         <= win_ls & ls_we;
         wdata_q      <= win_ls ? ls_wdata : 32'd0;
         err_q        <= ~win_legal;
         rdata_q      <= 32'd0;
      end else if (state_q == ACCESS && !we_q) begin
         rdata_q      <= mem_rdata;
      end
   end

   // Memory lines are idle outside ACCESS, so reset drops a pending write at once
   always_comb begin
      mem_read  = (state_q == ACCESS) & ~we_q;
      mem_write = (state_q == ACCESS) & we_q;
      mem_addr  = (state_q == ACCESS) ? addr_q  : 32'd0;
      mem_wdata = (state_q == ACCESS) ? wdata_q : 32'd0;
   end

   always_comb begin
      if_rvalid = (state_q == RESP) & ~owner_q;
      ls_rvalid = (state_q == RESP) & owner_q;
      if_rdata  = if_rvalid ? rdata_q : 32'd0;
      ls_rdata  = ls_rvalid ? rdata_q : 32'd0;
      if_err    = if_rvalid & err_q;
      ls_err    = ls_rvalid & err_q;
      busy      = (state_q != IDLE);
   end

`ifdef DMEM_ARB_STATS_EN
   // One response per RESP cycle; errors are counted only as errors
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_if_cnt    <= 16'd0;
         stat_ls_rd_cnt <= 16'd0;
         stat_ls_wr_cnt <= 16'd0;
         stat_err_cnt   <= 16'd0;
      end else if (state_q == RESP) begin
         if (err_q) begin
            if (stat_err_cnt != 16'hFFFF) stat_err_cnt <= stat_err_cnt + 16'd1;
         end else if (!owner_q) begin
            if (stat_if_cnt != 16'hFFFF) stat_if_cnt <= stat_if_cnt + 16'd1;
         end else if (we_q) begin
            if (stat_ls_wr_cnt != 16'hFFFF) stat_ls_wr_cnt <= stat_ls_wr_cnt + 16'd1;
         end else begin
            if (stat_ls_rd_cnt != 16'hFFFF) stat_ls_rd_cnt <= stat_ls_rd_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin and a fixed-priority instance
// share stimulus, each with its own big-endian byte memory model.
module tb_dmem_arbiter;

   logic        clk;
   logic        reset_n;
   logic        if_req, ls_req, ls_we;
   logic [31:0] if_addr, ls_addr, ls_wdata;

   logic        if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err;
   logic [31:0] if_rdata, ls_rdata;
   logic        mem_read, mem_write, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic        fp_if_gnt, fp_if_rvalid, fp_if_err, fp_ls_gnt, fp_ls_rvalid, fp_ls_err;
   logic [31:0] fp_if_rdata, fp_ls_rdata;
   logic        fp_mem_read, fp_mem_write, fp_busy;
   logic [31:0] fp_mem_addr, fp_mem_wdata, fp_mem_rdata;

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] s_if, s_rd, s_wr, s_err;
   logic [15:0] fs_if, fs_rd, fs_wr, fs_err;
`endif

   logic [7:0] mem    [0:31];
   logic [7:0] mem_fp [0:31];

   int checks;
   int errors;

   dmem_arbiter #(.MEM_BYTES(32), .FIXED_PRIO(0)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef DMEM_ARB_STATS_EN
      , .stat_if_cnt(s_if), .stat_ls_rd_cnt(s_rd), .stat_ls_wr_cnt(s_wr), .stat_err_cnt(s_err)
`endif
   );

   dmem_arbiter #(.MEM_BYTES(32), .FIXED_PRIO(1)) u_dut_fp (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(fp_if_gnt), .if_rvalid(fp_if_rvalid),
      .if_rdata(fp_if_rdata), .if_err(fp_if_err),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(fp_ls_gnt), .ls_rvalid(fp_ls_rvalid), .ls_rdata(fp_ls_rdata), .ls_err(fp_ls_err),
      .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_addr(fp_mem_addr),
      .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata), .busy(fp_busy)
`ifdef DMEM_ARB_STATS_EN
      , .stat_if_cnt(fs_if), .stat_ls_rd_cnt(fs_rd), .stat_ls_wr_cnt(fs_wr), .stat_err_cnt(fs_err)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Combinational big-endian reads
   always_comb begin
      logic [4:0] a;
      a = mem_addr[4:0];
      mem_rdata = mem_read ? {mem[a], mem[5'(a + 5'd1)], mem[5'(a + 5'd2)], mem[5'(a + 5'd3)]} : 32'd0;
   end

   always_comb begin
      logic [4:0] a;
      a = fp_mem_addr[4:0];
      fp_mem_rdata = fp_mem_read ? {mem_fp[a], mem_fp[5'(a + 5'd1)], mem_fp[5'(a + 5'd2)],
                                    mem_fp[5'(a + 5'd3)]} : 32'd0;
   end

   // Writes commit on the falling edge
   always @(negedge clk) begin
      if (mem_write) begin
         mem[mem_addr[4:0]]            <= mem_wdata[31:24];
         mem[5'(mem_addr[4:0] + 5'd1)] <= mem_wdata[23:16];
         mem[5'(mem_addr[4:0] + 5'd2)] <= mem_wdata[15:8];
         mem[5'(mem_addr[4:0] + 5'd3)] <= mem_wdata[7:0];
      end
      if (fp_mem_write) begin
         mem_fp[fp_mem_addr[4:0]]            <= fp_mem_wdata[31:24];
         mem_fp[5'(fp_mem_addr[4:0] + 5'd1)] <= fp_mem_wdata[23:16];
         mem_fp[5'(fp_mem_addr[4:0] + 5'd2)] <= fp_mem_wdata[15:8];
         mem_fp[5'(fp_mem_addr[4:0] + 5'd3)] <= fp_mem_wdata[7:0];
      end
   end

   function automatic logic [31:0] word_at(input logic [4:0] a);
      return {mem[a], mem[5'(a + 5'd1)], mem[5'(a + 5'd2)], mem[5'(a + 5'd3)]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset_n = 1'b0;
      if_req  = 1'b0;
      ls_req  = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   // One complete transaction from request to response, checking latency and memory enables
   task automatic txn(input string tag, input logic is_ls, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
      int   n;
      logic saw_rd, saw_wr, gnt, rv;
      @(posedge clk); #1;
      if (is_ls) begin
         ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      n = 0;
      @(negedge clk);
      gnt = is_ls ? ls_gnt : if_gnt;
      while (!gnt && n < 10) begin
         @(negedge clk);
         gnt = is_ls ? ls_gnt : if_gnt;
         n++;
      end
      check({tag, "_gnt"}, 32'(gnt), 32'd1);
      @(posedge clk); #1;
      if_req = 1'b0;
      ls_req = 1'b0;
      n = 0; saw_rd = 1'b0; saw_wr = 1'b0;
      do begin
         @(negedge clk);
         n++;
         saw_rd |= mem_read;
         saw_wr |= mem_write;
         rv = is_ls ? ls_rvalid : if_rvalid;
      end while (!rv && n < 6);
      check({tag, "_lat"}, 32'(n), exp_err ? 32'd1 : 32'd2);
      check({tag, "_rdata"}, is_ls ? ls_rdata : if_rdata, exp_rdata);
      check({tag, "_err"}, 32'(is_ls ? ls_err : if_err), 32'(exp_err));
      check({tag, "_other_rv"}, 32'(is_ls ? if_rvalid : ls_rvalid), 32'd0);
      check({tag, "_mem_rd"}, 32'(saw_rd), 32'(!exp_err && !we));
      check({tag, "_mem_wr"}, 32'(saw_wr), 32'(!exp_err && we));
   endtask

   initial begin
      int   n;
      logic exp_ls, saw;
      checks = 0;
      errors = 0;
      reset_n = 1'b0;
      if_req = 1'b0; if_addr = 32'd0;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0;
      for (int i = 0; i < 32; i++) begin
         mem[i]    = 8'(i);
         mem_fp[i] = 8'(i);
      end

      // Reset state
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rvalid", 32'({if_rvalid, ls_rvalid, if_err, ls_err}), 32'd0);
      check("rst_mem", 32'({mem_read, mem_write}), 32'd0);
      check("rst_maddr", mem_addr, 32'd0);
      check("rst_rdata", if_rdata | ls_rdata, 32'd0);
      @(posedge clk); #1 reset_n = 1'b1;

      // Write then read back; IF sees the same word
      txn("ls_wr8", 1'b1, 1'b1, 32'd8, 32'hDEADBEEF, 32'd0, 1'b0);
      check("mem8", word_at(5'd8), 32'hDEADBEEF);
      txn("ls_rd8", 1'b1, 1'b0, 32'd8, 32'd0, 32'hDEADBEEF, 1'b0);
      txn("if_rd8", 1'b0, 1'b0, 32'd8, 32'd0, 32'hDEADBEEF, 1'b0);
      txn("ls_rd28", 1'b1, 1'b0, 32'd28, 32'd0, 32'h1C1D1E1F, 1'b0);

      // Illegal addresses
      txn("ls_rd6", 1'b1, 1'b0, 32'd6, 32'd0, 32'd0, 1'b1);
      txn("ls_rd32", 1'b1, 1'b0, 32'd32, 32'd0, 32'd0, 1'b1);
      txn("ls_rd256", 1'b1, 1'b0, 32'h0000_0100, 32'd0, 32'd0, 1'b1);
      txn("if_rd256", 1'b0, 1'b0, 32'h0000_0100, 32'd0, 32'd0, 1'b1);
      txn("ls_wr256", 1'b1, 1'b1, 32'h0000_0100, 32'hCAFEF00D, 32'd0, 1'b1);
      check("mem0_kept", word_at(5'd0), 32'h00010203);

      // Contention from reset: RR alternates starting with IF, fixed priority always picks LS
      do_reset();
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'd16;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd12;
      for (int g = 0; g < 4; g++) begin
         exp_ls = (g % 2) == 1;
         n = 0;
         @(negedge clk);
         while (!(if_gnt || ls_gnt) && n < 10) begin
            @(negedge clk);
            n++;
         end
         check($sformatf("rr_if_gnt%0d", g), 32'(if_gnt), 32'(!exp_ls));
         check($sformatf("rr_ls_gnt%0d", g), 32'(ls_gnt), 32'(exp_ls));
         check($sformatf("fp_gnt%0d", g), 32'({fp_if_gnt, fp_ls_gnt}), 32'd1);
         @(negedge clk);
         @(negedge clk);
         check($sformatf("rr_rv%0d", g), 32'({if_rvalid, ls_rvalid}), exp_ls ? 32'd1 : 32'd2);
         check($sformatf("rr_data%0d", g), exp_ls ? ls_rdata : if_rdata,
               exp_ls ? 32'h0C0D0E0F : 32'h10111213);
         check($sformatf("fp_rv%0d", g), 32'({fp_if_rvalid, fp_ls_rvalid}), 32'd1);
         check($sformatf("fp_data%0d", g), fp_ls_rdata, 32'h0C0D0E0F);
      end
      @(posedge clk); #1;
      if_req = 1'b0;
      ls_req = 1'b0;

      // Reset during the ACCESS cycle of a write suppresses it
      @(posedge clk); #1;
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'd4; ls_wdata = 32'h11223344;
      @(negedge clk);
      check("rst_mid_gnt", 32'(ls_gnt), 32'd1);
      @(posedge clk); #1;
      check("rst_mid_mw", 32'(mem_write), 32'd1);
      reset_n = 1'b0;
      ls_req  = 1'b0;
      #1;
      check("rst_mid_mw0", 32'(mem_write), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_addr", mem_addr | mem_wdata, 32'd0);
      saw = 1'b0;
      repeat (2) begin
         @(negedge clk);
         saw |= ls_rvalid;
      end
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         saw |= ls_rvalid;
      end
      check("rst_mid_norv", 32'(saw), 32'd0);
      check("rst_mid_mem4", word_at(5'd4), 32'h04050607);

`ifdef DMEM_ARB_STATS_EN
      do_reset();
      @(negedge clk);
      check("stat_clr", 32'({s_if, s_rd}) | 32'({s_wr, s_err}), 32'd0);
      txn("st_if0", 1'b0, 1'b0, 32'd0, 32'd0, 32'h00010203, 1'b0);
      txn("st_if4", 1'b0, 1'b0, 32'd4, 32'd0, 32'h04050607, 1'b0);
      txn("st_if16", 1'b0, 1'b0, 32'd16, 32'd0, 32'h10111213, 1'b0);
      txn("st_wr20", 1'b1, 1'b1, 32'd20, 32'hA5A5A5A5, 32'd0, 1'b0);
      txn("st_wr24", 1'b1, 1'b1, 32'd24, 32'h5A5A5A5A, 32'd0, 1'b0);
      txn("st_rd20", 1'b1, 1'b0, 32'd20, 32'd0, 32'hA5A5A5A5, 1'b0);
      txn("st_mis", 1'b1, 1'b0, 32'd6, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
      check("stat_if", 32'(s_if), 32'd3);
      check("stat_rd", 32'(s_rd), 32'd1);
      check("stat_wr", 32'(s_wr), 32'd2);
      check("stat_err", 32'(s_err), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
